// File: rtl/result_display_unit.sv
// -----------------------------------------------------------------------------
// result_display_unit
//
// Output stage of the processor core. It takes the 8-bit output register value
// and the halt flag, and drives four active-low 7-segment digits and a blinking
// halt LED.
//
// The binary value goes through a sequential shift-add-3 (double-dabble)
// engine. The engine runs for eight cycles. The resulting BCD digits are then
// encoded to segments, with leading zeros suppressed. In signed mode, a
// negative two's-complement value is shown as its magnitude, with a minus sign
// in the leftmost digit position.
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset       in   synchronous, active-high reset
//   dataOut     in   [7:0] value from the processor output register
//   Halt        in   processor halted flag
//   signedMode  in   1 = interpret dataOut as two's complement
//   HEX0        out  [6:0] ones digit       (active-low, bit6=g .. bit0=a)
//   HEX1        out  [6:0] tens digit
//   HEX2        out  [6:0] hundreds digit
//   HEX3        out  [6:0] sign position (minus or blank)
//   busy        out  high while a conversion is running (CONV and DONE)
//   haltLed     out  blinking halt indicator
//
// Timing: a new key is seen in IDLE in cycle 0. CONV runs in cycles 1-8 and
// DONE is cycle 9. The new segments are visible from cycle 10.
// -----------------------------------------------------------------------------
module result_display_unit #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataOut,
  input  logic       Halt,
  input  logic       signedMode,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       busy,
  output logic       haltLed
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // The blink counter needs at least one bit. This keeps BLINK_DIV = 1 legal:
  // in that case the LED toggles on every cycle while halted.
  localparam int              CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Layout of the double-dabble register: {hundreds, tens, ones, binary}.
  logic [19:0] shift_reg;
  logic [2:0]  iter_cnt;
  logic [8:0]  cur_key;     // {signedMode, dataOut} as currently presented
  logic [8:0]  cap_key;     // key captured when the running conversion started
  logic [8:0]  last_key;    // key of the value currently on the display
  logic        neg;
  logic        force_conv;
  logic        trigger;
  logic [7:0]  load_val;

  logic [3:0]  bcd_hund;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic [6:0]  hex0_next;
  logic [6:0]  hex1_next;
  logic [6:0]  hex2_next;
  logic [6:0]  hex3_next;

  logic [CNT_W-1:0] blink_cnt;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Encodes one decimal digit as active-low segments (bit6=g .. bit0=a).
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Performs one double-dabble iteration. Every BCD nibble of 5 or more gets
  // +3 first, then the whole register shifts left by one bit. For 8-bit
  // inputs the hundreds nibble never exceeds 2, so it cannot overflow.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] a;
    a = r;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // Input key and load value
  // ---------------------------------------------------------------------------
  assign cur_key = {signedMode, dataOut};

  // This is a two's-complement negate. 8'h80 maps to itself, which reads as
  // an unsigned 128, so -128 converts correctly.
  assign load_val = (signedMode && dataOut[7]) ? (~dataOut + 8'd1) : dataOut;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples the pre-edge values. Blocking assignments here would create
  // order-dependent races between the always_ff blocks.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case. Otherwise a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    case (state)
      IDLE: begin
        trigger = force_conv || (cur_key != last_key);
        if (trigger) state_next = CONV;
      end
      CONV: begin
        // iter_cnt == 7 means this edge performs the eighth shift.
        if (iter_cnt == 3'd7) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Segment encoding of the finished BCD result, with leading-zero suppression
  // ---------------------------------------------------------------------------
  assign bcd_hund = shift_reg[19:16];
  assign bcd_tens = shift_reg[15:12];
  assign bcd_ones = shift_reg[11:8];

  always_comb begin
    hex0_next = seg_encode(bcd_ones);
    hex1_next = seg_encode(bcd_tens);
    hex2_next = seg_encode(bcd_hund);
    hex3_next = neg ? SEG_MINUS : SEG_BLANK;
    if (bcd_hund == 4'd0) begin
      hex2_next = SEG_BLANK;
      if (bcd_tens == 4'd0) hex1_next = SEG_BLANK;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath and display registers
  // ---------------------------------------------------------------------------
  // force_conv comes out of reset set. This makes the display show "0" after
  // reset even though last_key already matches an input of zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg  <= '0;
      iter_cnt   <= '0;
      cap_key    <= '0;
      last_key   <= '0;
      neg        <= 1'b0;
      force_conv <= 1'b1;
      HEX0       <= SEG_BLANK;
      HEX1       <= SEG_BLANK;
      HEX2       <= SEG_BLANK;
      HEX3       <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            cap_key    <= cur_key;
            neg        <= signedMode && dataOut[7];
            force_conv <= 1'b0;
            iter_cnt   <= '0;
            shift_reg  <= {12'd0, load_val};
          end
        end
        CONV: begin
          shift_reg <= dabble_step(shift_reg);
          iter_cnt  <= iter_cnt + 3'd1;
        end
        DONE: begin
          HEX0     <= hex0_next;
          HEX1     <= hex1_next;
          HEX2     <= hex2_next;
          HEX3     <= hex3_next;
          // Record the captured key, not the live input. If the input moved
          // during the conversion, the next IDLE cycle sees a difference and
          // retriggers.
          last_key <= cap_key;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Halt LED blink, independent of the conversion FSM
  // ---------------------------------------------------------------------------
  // The counter reaches CNT_MAX on the BLINK_DIV-th cycle of Halt being high.
  // The first toggle (to 1) therefore lands BLINK_DIV cycles after Halt rises.
  always_ff @(posedge clock) begin
    if (reset || !Halt) begin
      blink_cnt <= '0;
      haltLed   <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      haltLed   <= ~haltLed;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: doc/result_display_unit.md
Name: result_display_unit

Overview:
- Downstream stage of the processor core: consumes the 8-bit output register value and the halt flag, and drives the board's four active-low 7-segment displays plus a halt LED.
- Converts the binary value to decimal with a sequential shift-add-3 (double-dabble) engine, then encodes the digits to segments.
- Signed mode shows two's-complement values with a minus sign.
- The halt flag blinks an LED.

Parameters:
- BLINK_DIV, 25000000, clock cycles per halt-LED toggle (≥1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dataOut  input  8  value from the processor output register.
- Halt  input  1  processor halted flag.
- signedMode  input  1  1 = treat dataOut as two's complement.
- HEX0  output  7  ones digit, active-low segments, bit6=g … bit0=a.
- HEX1  output  7  tens digit.
- HEX2  output  7  hundreds digit.
- HEX3  output  7  sign position.
- busy  output  1  high while a conversion is in progress.
- haltLed  output  1  blinking halt indicator.

Behaviour:
- One clock; reset is synchronous and active-high. Reset has priority over all other activity, including mid-conversion.
- Reset values:
  - HEX0..HEX3 = 7'b1111111 (blank).
  - busy = 0, haltLed = 0, state = IDLE.
  - lastVal = 0; blink counter = 0.
  - forceConv = 1, so "0" appears 10 cycles after reset release.
- State machine IDLE → CONV → DONE → IDLE.
- IDLE:
  - Trigger when {signedMode, dataOut} != lastKey or forceConv = 1.
  - On trigger: capture dataOut and signedMode, clear forceConv, clear the iteration counter, load the shift register, go to CONV.
  - Load value: magnitude if signedMode && dataOut[7] (two's-complement negate; 8'h80 → 128), else dataOut.
  - Record neg = signedMode && dataOut[7].
- CONV, exactly 8 cycles, each cycle:
  - Every BCD nibble (hundreds, tens, ones) ≥ 5 gets +3.
  - Then the 20-bit {BCD, binary} register shifts left 1.
  - The counter increments; after the 8th shift go to DONE.
  - busy = 1 throughout CONV and DONE.
- DONE (1 cycle):
  - Register HEX0..HEX3 from the BCD result.
  - Set lastKey to the captured {signedMode, value}.
  - Return to IDLE.
- Latency: trigger seen in cycle 0 → CONV in cycles 1–8 → DONE in cycle 9 → new segments visible from cycle 10.
- Input changes during CONV/DONE are ignored for the running conversion. The next IDLE cycle compares against the captured key and retriggers if different. A value that changes and returns before IDLE causes no retrigger.
- Leading-zero suppression:
  - HEX2 blank if hundreds = 0.
  - HEX1 blank if hundreds = 0 and tens = 0.
  - HEX0 always shown.
- Sign display:
  - HEX3 = minus (7'b0111111) when neg, otherwise blank.
  - The minus always sits in HEX3, not adjacent to the digits.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Halt blink:
  - While Halt = 1 the counter increments. When it reaches BLINK_DIV-1 it wraps to 0 and haltLed toggles.
  - The first toggle, to 1, occurs BLINK_DIV cycles after Halt rises.
  - When Halt = 0: counter = 0 and haltLed = 0 on the next edge.
  - The blink logic is independent of the conversion FSM.

Test Plan:
- Reset for 2 cycles, dataOut = 0, then release → HEX0..HEX3 blank until cycle 10; then HEX0 = 1000000 and HEX1/HEX2/HEX3 blank. busy is high for cycles 1–9 after release.
- Unsigned, dataOut = 8'd255 → HEX2 = 0100100, HEX1 = 0010010, HEX0 = 0010010, HEX3 blank; update lands exactly 10 cycles after the change.
- signedMode = 1, dataOut = 8'h80 → HEX3 = 0111111, HEX2 = 1111001, HEX1 = 0100100, HEX0 = 0000000 (−128). With dataOut = 8'hF6 → −10: HEX2 blank, HEX1 = 1111001, HEX0 = 1000000.
- dataOut 8'd7 → 8'd42 in cycle 3 of a conversion → 7 is displayed first, then a second conversion starts in the next IDLE cycle and 42 is displayed (HEX1 = 0011001, HEX0 = 0100100).
- Reset asserted in cycle 5 of a conversion → all outputs return to reset values the next edge; after release "0" appears 10 cycles later.
- BLINK_DIV = 4, Halt high for 20 cycles then low → haltLed toggles every 4 cycles starting 4 cycles after Halt rises, and is 0 one cycle after Halt falls.
